id_stage_queued: RTL
====================

// Module: id_stage_queued
// PURPOSE
//  Parametrised decode stage for the pipelined MIPS core, successor to the fixed ID stage.
//  Adds a DEPTH-entry instruction queue between IF and decode, valid/ready handshakes on both
//  sides, and a registered ID/EX output. Branches and jumps resolve in ID, with a redirect pulse
//  and a queue flush. Sits between the IF stage and the ID/EX consumer (EXE stage).
// PARAMETERS
//  WORD_LEN        32  data/PC width; must be >= 32
//  DEPTH           4   instruction queue entries; power of 2, >= 2
//  ZERO_EXT_LOGIC  1   1: ANDI/ORI/XORI zero-extend imm; 0: all immediates sign-extend
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         asynchronous, active-low reset
//  in_valid      in   1         IF offers instruction
//  in_ready      out  1         queue can accept: count < DEPTH
//  in_instr      in   32        instruction word
//  in_pc         in   WORD_LEN  PC of in_instr
//  rs_addr       out  5         register-file read addr = head[25:21] (combinational)
//  rt_addr       out  5         register-file read addr = head[20:16] (combinational)
//  rs_value      in   WORD_LEN  register-file data for rs_addr, same cycle
//  rt_value      in   WORD_LEN  register-file data for rt_addr, same cycle
//  hazard_stall  in   1         hazard unit: hold the head instruction this cycle
//  flush         in   1         discard queue contents and the output register
//  out_valid     out  1         ID/EX register holds a valid instruction
//  out_ready     in   1         EXE consumes the output register
//  out_opcode    out  6         instr[31:26]
//  out_funct     out  6         instr[5:0]
//  out_shamt     out  5         instr[10:6]
//  out_rs/out_rt out  5 each    source register addresses (for forwarding)
//  out_dest      out  5         rt if is_imm, else rd; 0 for SW/BEQ/BNE/J
//  out_val1      out  WORD_LEN  rs_value
//  out_val2      out  WORD_LEN  extended immediate if is_imm, else rt_value
//  out_st_data   out  WORD_LEN  rt_value (SW store data)
//  out_is_imm/out_mem_read/out_mem_write/out_wb_en  out 1 each   decoded controls
//  out_illegal   out  1         opcode not in the decoded set
//  redirect      out  1         one-cycle pulse: taken branch or jump issued
//  redirect_pc   out  WORD_LEN  fetch target, held until the next redirect
//  occupancy     out  log2(DEPTH)+1  current queue count
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): queue empty, pointers 0, every output register 0, out_valid=0, redirect=0.
//  - Enqueue on in_valid&in_ready. No bypass: a word accepted at edge E0 issues at E1 at the earliest.
//  - Issue condition: head valid & !hazard_stall & !flush & (!out_valid | out_ready).
//    On issue: pop the head and load all out_* fields at the edge.
//    If out_ready is high with no issue, out_valid clears (bubble).
//    If out_valid is high and out_ready is low, the output register holds all fields.
//  - Decoded opcodes:
//      R-type 0x00: wb_en=1.
//      ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, SLTI 0x0A: is_imm=1, wb_en=1.
//      LW 0x23: is_imm=1, mem_read=1, wb_en=1.
//      SW 0x2B: is_imm=1, mem_write=1.
//      BEQ 0x04, BNE 0x05, J 0x02: all control outputs 0.
//      Any other opcode: all controls 0 and illegal=1; it still issues as a NOP.
//  - Branch resolution at issue:
//      BEQ taken if rs_value==rt_value; BNE taken if they differ.
//      Branch target = pc+4 + (sext(imm)<<2), mod 2^WORD_LEN.
//      J target = {pc+4[WORD_LEN-1:28], instr[25:0], 2'b00}.
//  - Taken branch or J issued at edge E:
//      redirect=1 and redirect_pc=target for exactly the cycle after E.
//      All younger queue entries are discarded at E, including a word enqueued at E.
//      There is no delay slot.
//  - flush=1 at an edge:
//      queue emptied, out_valid=0, redirect=0; a concurrent enqueue is dropped.
//      flush has priority over issue, redirect and enqueue.
//  - A stalled head re-samples rs_value/rt_value every cycle, so the value at the issue edge is used.
//  - Full queue: in_ready=0. A simultaneous pop and push is allowed only when count<DEPTH,
//    because in_ready depends on count and not on the pop.
//  - Pointers wrap mod DEPTH; occupancy never exceeds DEPTH.
// TESTING
//  1 Reset mid-stream:
//      fill 3 entries, pulse rst low -> occupancy=0, out_valid=0 and all outputs 0 immediately.
//  2 Stream:
//      ADDI $2,$1,-1 (0x2022FFFF), rs_value=5 ->
//      next cycle out_valid=1, out_val2=0xFFFFFFFF, out_dest=2, wb_en=1, is_imm=1.
//  3 ORI zero-extend:
//      ORI imm 0x8000 with ZERO_EXT_LOGIC=1 -> out_val2=0x00008000; with ZERO_EXT_LOGIC=0 -> 0xFFFF8000.
//  4 Taken BEQ:
//      BEQ at pc=0x100, imm=3, rs=rt=7, two younger entries queued ->
//      redirect=1 for 1 cycle, redirect_pc=0x110, occupancy=0.
//      The same branch with rs!=rt -> no redirect; younger entries issue in order.
//  5 Backpressure and stall:
//      out_ready=0 for 4 cycles with in_valid=1 -> queue fills, in_ready=0 at DEPTH, outputs stable.
//      Then hazard_stall=1 for 2 cycles with out_ready=1 -> out_valid=0 for those 2 cycles.
//  6 Flush vs redirect:
//      flush and a taken J in the same cycle -> no redirect, queue empty, out_valid=0.

Source files
------------

// File: rtl/id_stage_queued.sv
// Queued MIPS decode stage: DEPTH-entry instruction FIFO from IF, decode with branch/jump
// resolution at issue, and a registered ID/EX output with valid/ready handshake.
module id_stage_queued #(
    parameter int WORD_LEN       = 32,
    parameter int DEPTH          = 4,
    parameter int ZERO_EXT_LOGIC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [WORD_LEN-1:0]       in_pc,
    output logic [4:0]                rs_addr,
    output logic [4:0]                rt_addr,
    input  logic [WORD_LEN-1:0]       rs_value,
    input  logic [WORD_LEN-1:0]       rt_value,
    input  logic                      hazard_stall,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [5:0]                out_opcode,
    output logic [5:0]                out_funct,
    output logic [4:0]                out_shamt,
    output logic [4:0]                out_rs,
    output logic [4:0]                out_rt,
    output logic [4:0]                out_dest,
    output logic [WORD_LEN-1:0]       out_val1,
    output logic [WORD_LEN-1:0]       out_val2,
    output logic [WORD_LEN-1:0]       out_st_data,
    output logic                      out_is_imm,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_wb_en,
    output logic                      out_illegal,
    output logic                      redirect,
    output logic [WORD_LEN-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0]         instr_mem_q [DEPTH];
    logic [WORD_LEN-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]         count_q, count_d;

    logic                head_valid;
    logic [31:0]         head_instr;
    logic [WORD_LEN-1:0] head_pc;
    logic                issue, push, taken;

    logic [5:0]          opcode;
    logic                is_imm, mem_read, mem_write, wb_en, illegal;
    logic                is_logic, is_beq, is_bne, is_j, no_dest;
    logic [4:0]          dest;
    logic [WORD_LEN-1:0] imm_sext, imm_ext, pc_plus4, br_target, j_target, target;

    logic                out_valid_q, out_is_imm_q, out_mem_read_q, out_mem_write_q;
    logic                out_wb_en_q, out_illegal_q, redirect_q;
    logic [5:0]          out_opcode_q, out_funct_q;
    logic [4:0]          out_shamt_q, out_rs_q, out_rt_q, out_dest_q;
    logic [WORD_LEN-1:0] out_val1_q, out_val2_q, out_st_data_q, redirect_pc_q;

    assign head_valid = (count_q != '0);
    // Empty queue presents an all-zero head so the register-file addresses read 0.
    assign head_instr = head_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign head_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign rs_addr    = head_instr[25:21];
    assign rt_addr    = head_instr[20:16];
    assign in_ready   = (count_q < (AW+1)'(DEPTH));
    assign occupancy  = count_q;

    always_comb begin
        opcode    = head_instr[31:26];
        is_imm    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_en     = 1'b0;
        illegal   = 1'b0;
        is_logic  = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        no_dest   = 1'b0;
        case (opcode)
            OP_RTYPE: wb_en = 1'b1;
            OP_ADDI, OP_SLTI: begin
                is_imm = 1'b1;
                wb_en  = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                is_imm   = 1'b1;
                wb_en    = 1'b1;
                is_logic = 1'b1;
            end
            OP_LW: begin
                is_imm   = 1'b1;
                mem_read = 1'b1;
                wb_en    = 1'b1;
            end
            OP_SW: begin
                is_imm    = 1'b1;
                mem_write = 1'b1;
                no_dest   = 1'b1;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                no_dest = 1'b1;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                no_dest = 1'b1;
            end
            OP_J: begin
                is_j    = 1'b1;
                no_dest = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign dest      = no_dest ? 5'd0 : (is_imm ? head_instr[20:16] : head_instr[15:11]);
    assign imm_sext  = {{(WORD_LEN-16){head_instr[15]}}, head_instr[15:0]};
    assign imm_ext   = (ZERO_EXT_LOGIC != 0 && is_logic) ? {{(WORD_LEN-16){1'b0}}, head_instr[15:0]}
                                                        : imm_sext;
    assign pc_plus4  = head_pc + WORD_LEN'(4);
    assign br_target = pc_plus4 + {imm_sext[WORD_LEN-3:0], 2'b00};
    assign j_target  = {pc_plus4[WORD_LEN-1:28], head_instr[25:0], 2'b00};
    assign target    = is_j ? j_target : br_target;

    assign issue = head_valid & ~hazard_stall & ~flush & (~out_valid_q | out_ready);
    assign taken = issue & (is_j | (is_beq & (rs_value == rt_value)) | (is_bne & (rs_value != rt_value)));
    assign push  = in_valid & in_ready & ~flush & ~taken;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush || taken) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
            if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(issue);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            out_valid_q     <= 1'b0;
            out_opcode_q    <= '0;
            out_funct_q     <= '0;
            out_shamt_q     <= '0;
            out_rs_q        <= '0;
            out_rt_q        <= '0;
            out_dest_q      <= '0;
            out_val1_q      <= '0;
            out_val2_q      <= '0;
            out_st_data_q   <= '0;
            out_is_imm_q    <= 1'b0;
            out_mem_read_q  <= 1'b0;
            out_mem_write_q <= 1'b0;
            out_wb_en_q     <= 1'b0;
            out_illegal_q   <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            redirect_q <= taken;
            if (taken) redirect_pc_q <= target;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (issue) begin
                out_valid_q     <= 1'b1;
                out_opcode_q    <= opcode;
                out_funct_q     <= head_instr[5:0];
                out_shamt_q     <= head_instr[10:6];
                out_rs_q        <= head_instr[25:21];
                out_rt_q        <= head_instr[20:16];
                out_dest_q      <= dest;
                out_val1_q      <= rs_value;
                out_val2_q      <= is_imm ? imm_ext : rt_value;
                out_st_data_q   <= rt_value;
                out_is_imm_q    <= is_imm;
                out_mem_read_q  <= mem_read;
                out_mem_write_q <= mem_write;
                out_wb_en_q     <= wb_en;
                out_illegal_q   <= illegal;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_funct     = out_funct_q;
    assign out_shamt     = out_shamt_q;
    assign out_rs        = out_rs_q;
    assign out_rt        = out_rt_q;
    assign out_dest      = out_dest_q;
    assign out_val1      = out_val1_q;
    assign out_val2      = out_val2_q;
    assign out_st_data   = out_st_data_q;
    assign out_is_imm    = out_is_imm_q;
    assign out_mem_read  = out_mem_read_q;
    assign out_mem_write = out_mem_write_q;
    assign out_wb_en     = out_wb_en_q;
    assign out_illegal   = out_illegal_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
endmodule
